// File: rtl/cache_ctr_burst_pkg.sv
// Shared encodings for the burst cache controller: bus direction codes,
// data-path mux/tristate selects, FSM states and request dispatch.
package cache_ctr_burst_pkg;

  // System bus direction; the idle code is a don't-care held low.
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_UNK   = 1'b0;

  // Cache data-array input source.
  localparam logic CDATA_SYS = 1'b1;
  localparam logic CDATA_PRO = 1'b0;

  // Processor data source.
  localparam logic PDATA_CAC = 1'b0;
  localparam logic PDATA_SYS = 1'b1;

  // Bus drivers.
  localparam logic SDATA_OPEN  = 1'b1;
  localparam logic SDATA_CLOSE = 1'b0;
  localparam logic PDATA_OPEN  = 1'b1;
  localparam logic PDATA_CLOSE = 1'b0;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_RD_LOOK   = 4'd1,
    S_FILL_REQ  = 4'd2,
    S_FILL_WAIT = 4'd3,
    S_FILL_BEAT = 4'd4,
    S_FILL_DONE = 4'd5,
    S_WR_LOOK   = 4'd6,
    S_WR_REQ    = 4'd7,
    S_WR_WAIT   = 4'd8,
    S_WR_DONE   = 4'd9
  } state_t;

  // Next state when a new processor request may be accepted.
  function automatic state_t dispatch(input logic strobe, input logic rw);
    if (!strobe) return S_IDLE;
    return (rw == RW_READ) ? S_RD_LOOK : S_WR_LOOK;
  endfunction

endpackage

// File: rtl/cache_ctr_burst_if.sv
// Processor/system-bus/cache-array control signals of the burst cache controller.
// slave = controller side, master = environment (processor, bus, arrays).
interface cache_ctr_burst_if #(
  parameter int unsigned LINE_WORDS = 4
);
  localparam int unsigned WIDX_W = $clog2(LINE_WORDS);

  logic              PStrobe;
  logic              PRw;
  logic [WIDX_W-1:0] PWordIdx;
  logic              PReady;
  logic              tag_match;
  logic              valid;
  logic              SysStrobe;
  logic              SysRW;
  logic              write;
  logic              set_valid;
  logic [WIDX_W-1:0] fill_index;
  logic              select_CData;
  logic              select_PData;
  logic              open_SysData;
  logic              open_PData;

  modport slave (
    input  PStrobe, PRw, PWordIdx, tag_match, valid,
    output PReady, SysStrobe, SysRW, write, set_valid, fill_index,
           select_CData, select_PData, open_SysData, open_PData
  );

  modport master (
    output PStrobe, PRw, PWordIdx, tag_match, valid,
    input  PReady, SysStrobe, SysRW, write, set_valid, fill_index,
           select_CData, select_PData, open_SysData, open_PData
  );
endinterface

// File: rtl/cache_ctr_burst_wait_ctr.sv
// cache_wait_ctr: 4-bit loadable down-counter with zero flag, used to
// time system-bus wait states.
module cache_wait_ctr (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic       dec,
  input  logic [3:0] load_val,
  output logic       zero
);
  logic [3:0] count;

  // Load has priority; decrement saturates at zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                   count <= '0;
    else if (load)               count <= load_val;
    else if (dec && count != '0) count <= count - 4'd1;
  end

  assign zero = (count == '0);
endmodule

// File: rtl/cache_ctr_burst.sv
// cache_ctr_burst: write-through, direct-mapped cache controller with
// multi-word line fill and programmable bus wait states.
// Optional feature macro: EARLY_RESTART_EN (return the requested word to
// the processor on its fill beat instead of after the whole line).
module cache_ctr_burst
  import cache_ctr_burst_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 2,
  parameter int unsigned LINE_WORDS  = 4
) (
  input logic              clock,
  input logic              reset,
  cache_ctr_burst_if.slave bus
);
  localparam int unsigned       WIDX_W   = $clog2(LINE_WORDS);
  localparam logic [WIDX_W-1:0] LAST_IDX = WIDX_W'(LINE_WORDS - 1);
  localparam logic [3:0]        WS       = 4'(WAIT_STATES);

  state_t            state, next;
  logic [WIDX_W-1:0] fill_index;
  logic              hit;
  logic              ctr_load, ctr_dec, ctr_zero;
  logic              fill_clr, fill_inc, hit_load;

  logic ready, sys_strobe, sys_rw, wr_en, set_val;
  logic sel_cdata, sel_pdata, open_sdata, open_pdata;

  cache_wait_ctr u_wait (
    .clock    (clock),
    .reset    (reset),
    .load     (ctr_load),
    .dec      (ctr_dec),
    .load_val (WS),
    .zero     (ctr_zero)
  );

  // State register, fill word index and latched write-hit flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      fill_index <= '0;
      hit        <= 1'b0;
    end else begin
      state <= next;
      if (fill_clr)      fill_index <= '0;
      else if (fill_inc) fill_index <= fill_index + WIDX_W'(1);
      if (hit_load)      hit <= bus.tag_match && bus.valid;
    end
  end

  // Next-state and output decode.
  always_comb begin
    next       = state;
    ready      = 1'b0;
    sys_strobe = 1'b0;
    sys_rw     = RW_UNK;
    wr_en      = 1'b0;
    set_val    = 1'b0;
    sel_cdata  = CDATA_PRO;
    sel_pdata  = PDATA_CAC;
    open_sdata = SDATA_CLOSE;
    open_pdata = PDATA_CLOSE;
    ctr_load   = 1'b0;
    ctr_dec    = 1'b0;
    fill_clr   = 1'b0;
    fill_inc   = 1'b0;
    hit_load   = 1'b0;
    case (state)
      S_IDLE: next = dispatch(bus.PStrobe, bus.PRw);
      S_RD_LOOK: begin
        sel_pdata  = PDATA_CAC;
        open_pdata = PDATA_OPEN;
        if (bus.tag_match && bus.valid) begin
          ready = 1'b1;
          next  = dispatch(bus.PStrobe, bus.PRw);
        end else begin
          fill_clr = 1'b1;
          next     = S_FILL_REQ;
        end
      end
      S_FILL_REQ: begin
        sys_strobe = 1'b1;
        sys_rw     = RW_READ;
        ctr_load   = 1'b1;
        next       = S_FILL_WAIT;
      end
      S_FILL_WAIT: begin
        if (ctr_zero) next = S_FILL_BEAT;
        else          ctr_dec = 1'b1;
      end
      S_FILL_BEAT: begin
        wr_en     = 1'b1;
        sel_cdata = CDATA_SYS;
        fill_inc  = 1'b1;
`ifdef EARLY_RESTART_EN
        if (fill_index == bus.PWordIdx) begin
          ready      = 1'b1;
          sel_pdata  = PDATA_SYS;
          open_pdata = PDATA_OPEN;
        end
`endif
        if (fill_index == LAST_IDX) begin
          set_val = 1'b1;
          next    = S_FILL_DONE;
        end else begin
          next = S_FILL_REQ;
        end
      end
      S_FILL_DONE: begin
`ifdef EARLY_RESTART_EN
        // The word was already returned on its beat; just close out the fill.
        next = S_IDLE;
`else
        ready      = 1'b1;
        sel_pdata  = PDATA_CAC;
        open_pdata = PDATA_OPEN;
        next       = dispatch(bus.PStrobe, bus.PRw);
`endif
      end
      S_WR_LOOK: begin
        hit_load = 1'b1;
        next     = S_WR_REQ;
      end
      S_WR_REQ: begin
        sys_strobe = 1'b1;
        sys_rw     = RW_WRITE;
        open_sdata = SDATA_OPEN;
        sel_cdata  = CDATA_PRO;
        wr_en      = hit;
        ctr_load   = 1'b1;
        next       = S_WR_WAIT;
      end
      S_WR_WAIT: begin
        if (ctr_zero) next = S_WR_DONE;
        else          ctr_dec = 1'b1;
      end
      S_WR_DONE: begin
        ready = 1'b1;
        next  = S_IDLE;
      end
      default: next = S_IDLE;
    endcase
  end

`ifndef EARLY_RESTART_EN
  logic unused_widx;
  assign unused_widx = ^bus.PWordIdx;
`endif

  assign bus.PReady       = ready;
  assign bus.SysStrobe    = sys_strobe;
  assign bus.SysRW        = sys_rw;
  assign bus.write        = wr_en;
  assign bus.set_valid    = set_val;
  assign bus.fill_index   = fill_index;
  assign bus.select_CData = sel_cdata;
  assign bus.select_PData = sel_pdata;
  assign bus.open_SysData = open_sdata;
  assign bus.open_PData   = open_pdata;
endmodule

// File: tb/tb_cache_ctr_burst.sv
// Directed bench for cache_ctr_burst (WAIT_STATES=2, LINE_WORDS=4).
// Honours EARLY_RESTART_EN when the macro is defined for the build.
module tb_cache_ctr_burst;
  import cache_ctr_burst_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad   = 0;

  cache_ctr_burst_if #(.LINE_WORDS(4)) bus ();

  cache_ctr_burst #(.WAIT_STATES(2), .LINE_WORDS(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  // {PReady, SysStrobe, write, set_valid, select_CData, select_PData,
  //  open_SysData, open_PData, fill_index}
  function automatic logic [9:0] obs();
    return {bus.PReady, bus.SysStrobe, bus.write, bus.set_valid,
            bus.select_CData, bus.select_PData, bus.open_SysData,
            bus.open_PData, bus.fill_index};
  endfunction

  function automatic logic [9:0] ex(input logic r, s, w, v, c, p, so, po,
                                    input logic [1:0] fi);
    return {r, s, w, v, c, p, so, po, fi};
  endfunction

  task automatic chk(input string tag, input logic [9:0] got, input logic [9:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  localparam logic [9:0] IDLE_OUT = 10'b0;

  initial begin
    bus.PStrobe   = 1'b0;
    bus.PRw       = RW_READ;
    bus.PWordIdx  = 2'd2;
    bus.tag_match = 1'b0;
    bus.valid     = 1'b0;

    // Asynchronous reset, checked before any clock edge.
    #1 reset = 1'b1;
    #1;
    chk("reset_outs", obs(), IDLE_OUT);
    chk("reset_sysrw", {9'b0, bus.SysRW}, {9'b0, RW_UNK});
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b0;

    // Read hit, held for a back-to-back second hit.
    next_cycle();
    bus.PStrobe = 1'b1; bus.PRw = RW_READ; bus.tag_match = 1'b1; bus.valid = 1'b1;
    settle(); chk("rh_idle", obs(), IDLE_OUT);
    next_cycle(); settle();
    chk("rh_look", obs(), ex(1,0,0,0,0,0,0,1,2'd0));
    next_cycle(); bus.PStrobe = 1'b0; settle();
    chk("rh_b2b", obs(), ex(1,0,0,0,0,0,0,1,2'd0));
    next_cycle(); settle();
    chk("rh_after", obs(), IDLE_OUT);

    // Read miss: four beats, each REQ + 3 WAIT + BEAT.
    next_cycle();
    bus.PStrobe = 1'b1; bus.PRw = RW_READ; bus.tag_match = 1'b0; bus.valid = 1'b0;
    settle(); chk("rm_idle", obs(), IDLE_OUT);
    next_cycle(); settle();
    chk("rm_look", obs(), ex(0,0,0,0,0,0,0,1,2'd0));
    for (int b = 0; b < 4; b++) begin
      next_cycle(); settle();
      chk("rm_req", obs(), ex(0,1,0,0,0,0,0,0,2'(b)));
      chk("rm_req_rw", {9'b0, bus.SysRW}, {9'b0, RW_READ});
      for (int w = 0; w < 3; w++) begin
        next_cycle(); settle();
        chk("rm_wait", obs(), ex(0,0,0,0,0,0,0,0,2'(b)));
      end
      next_cycle(); settle();
`ifdef EARLY_RESTART_EN
      if (b == 2) chk("rm_beat_early", obs(), ex(1,0,1,0,1,1,0,1,2'(b)));
      else        chk("rm_beat", obs(), ex(0,0,1,(b == 3),1,0,0,0,2'(b)));
`else
      chk("rm_beat", obs(), ex(0,0,1,(b == 3),1,0,0,0,2'(b)));
`endif
    end
    next_cycle(); bus.PStrobe = 1'b0; settle();
`ifdef EARLY_RESTART_EN
    chk("rm_done", obs(), IDLE_OUT);
`else
    chk("rm_done", obs(), ex(1,0,0,0,0,0,0,1,2'd0));
`endif
    next_cycle(); settle();
    chk("rm_after", obs(), IDLE_OUT);

    // Write hit; tag/valid change after lookup must not affect the latched hit.
    next_cycle();
    bus.PStrobe = 1'b1; bus.PRw = RW_WRITE; bus.tag_match = 1'b1; bus.valid = 1'b1;
    settle(); chk("wh_idle", obs(), IDLE_OUT);
    next_cycle(); settle();
    chk("wh_look", obs(), IDLE_OUT);
    next_cycle(); bus.tag_match = 1'b0; bus.valid = 1'b0; settle();
    chk("wh_req", obs(), ex(0,1,1,0,0,0,1,0,2'd0));
    chk("wh_req_rw", {9'b0, bus.SysRW}, {9'b0, RW_WRITE});
    for (int w = 0; w < 3; w++) begin
      next_cycle(); settle();
      chk("wh_wait", obs(), IDLE_OUT);
    end
    next_cycle(); settle();
    chk("wh_done", obs(), ex(1,0,0,0,0,0,0,0,2'd0));
    // PStrobe still high in WR_DONE: no new write may start.
    next_cycle(); bus.PStrobe = 1'b0; settle();
    chk("wh_no_b2b_a", obs(), IDLE_OUT);
    next_cycle(); settle();
    chk("wh_no_b2b_b", obs(), IDLE_OUT);

    // Write miss: bus write only.
    next_cycle();
    bus.PStrobe = 1'b1; bus.PRw = RW_WRITE; bus.tag_match = 1'b1; bus.valid = 1'b0;
    settle(); chk("wm_idle", obs(), IDLE_OUT);
    next_cycle(); settle();
    chk("wm_look", obs(), IDLE_OUT);
    next_cycle(); settle();
    chk("wm_req", obs(), ex(0,1,0,0,0,0,1,0,2'd0));
    chk("wm_req_rw", {9'b0, bus.SysRW}, {9'b0, RW_WRITE});
    for (int w = 0; w < 3; w++) begin
      next_cycle(); settle();
      chk("wm_wait", obs(), IDLE_OUT);
    end
    next_cycle(); bus.PStrobe = 1'b0; settle();
    chk("wm_done", obs(), ex(1,0,0,0,0,0,0,0,2'd0));
    next_cycle(); settle();
    chk("wm_after", obs(), IDLE_OUT);

    // Reset during the first wait cycle of beat 2.
    next_cycle();
    bus.PStrobe = 1'b1; bus.PRw = RW_READ; bus.tag_match = 1'b0; bus.valid = 1'b0;
    next_cycle();                                   // RD_LOOK
    for (int k = 0; k < 10; k++) next_cycle();      // beats 0 and 1
    next_cycle();                                   // beat 2 REQ
    next_cycle(); settle();                         // beat 2 first WAIT
    chk("rst_pre", obs(), ex(0,0,0,0,0,0,0,0,2'd2));
    reset = 1'b1;
    #1;
    chk("rst_mid", obs(), IDLE_OUT);
    next_cycle();
    reset = 1'b0;
    settle(); chk("rst_idle", obs(), IDLE_OUT);
    next_cycle(); settle();
    chk("rst_relook", obs(), ex(0,0,0,0,0,0,0,1,2'd0));
    next_cycle(); bus.PStrobe = 1'b0; settle();
    chk("rst_refill", obs(), ex(0,1,0,0,0,0,0,0,2'd0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
